// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the shared-register write arbiter and its
// round-robin picker.
package reg_write_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    localparam logic OP_LD  = 1'b0;
    localparam logic OP_CLR = 1'b1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping to the lowest requests below it.
module rr_priority_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_onehot_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             valid_o
);

    logic found;

    // Upper pass covers [ptr, N_REQ), lower pass covers [0, ptr).
    always_comb begin
        win_onehot_o = '0;
        win_idx_o    = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
                found           = 1'b1;
                win_onehot_o[i] = 1'b1;
                win_idx_o       = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (IDX_W'(i) < ptr_i)) begin
                found           = 1'b1;
                win_onehot_o[i] = 1'b1;
                win_idx_o       = IDX_W'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/reg_write_arbiter.sv
// Sequences load/clear writes from N_REQ requesters into one shared register
// using a req/gnt/ack handshake with round-robin priority.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_clr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic                    c_ld,
    output logic                    c_clr,
    output logic [DATA_W-1:0]       d_out,
    output logic                    busy
);

    localparam int unsigned IDX_W = idx_width(N_REQ);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                c_ld_q, c_ld_d;
    logic                c_clr_q, c_clr_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
    logic                busy_q, busy_d;

    logic [N_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_clr;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i        (req),
        .ptr_i        (ptr_q),
        .win_onehot_o (pick_onehot),
        .win_idx_o    (pick_idx),
        .valid_o      (pick_valid)
    );

    // One-hot mux of the winner's operands.
    always_comb begin
        sel_data = '0;
        sel_clr  = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_clr  = req_clr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            c_ld_q  <= 1'b0;
            c_clr_q <= 1'b0;
            d_out_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            c_ld_q  <= c_ld_d;
            c_clr_q <= c_clr_d;
            d_out_q <= d_out_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so that every port is a flop.
    always_comb begin
        gnt_d   = '0;
        ack_d   = '0;
        c_ld_d  = 1'b0;
        c_clr_d = 1'b0;
        d_out_d = '0;
        win_d   = win_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    win_d   = pick_idx;
                    c_clr_d = (sel_clr == OP_CLR);
                    c_ld_d  = (sel_clr == OP_LD);
                    d_out_d = (sel_clr == OP_CLR) ? '0 : sel_data;
                end
            end
            ISSUE: begin
                gnt_d   = gnt_q;
                ack_d   = gnt_q;
                d_out_d = d_out_q;
            end
            ACK: begin
                ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign c_ld  = c_ld_q;
    assign c_clr = c_clr_q;
    assign d_out = d_out_q;
    assign busy  = busy_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(c_ld && c_clr));
    a_strobe_issue: assert property (@(posedge clk) disable iff (reset)
        (c_ld || c_clr) |-> (state_q == ISSUE));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one 16-bit load/clear register between N_REQ requesters.
- Sequences the register's c_ld / c_clr strobes and d_in data with a req/gnt/ack handshake.
- Round-robin priority gives each active requester a guaranteed write slot.
- Sits between the control units of the datapath and the shared register; the register's q is read directly by consumers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 16, data width; must match the shared register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester write request; held high until ack.
- req_clr  in  N_REQ  per-requester op select: 1 = clear register, 0 = load req_data.
- req_data  in  N_REQ*DATA_W  per-requester write data; slice i = bits [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot grant to the requester being served.
- ack  out  N_REQ  one-cycle pulse to the served requester when the register holds its value.
- c_ld  out  1  load strobe to the shared register.
- c_clr  out  1  clear strobe to the shared register.
- d_out  out  DATA_W  data to the shared register d_in.
- busy  out  1  high in every non-IDLE state.

Behaviour:
- Reset values: state = IDLE, gnt = 0, ack = 0, c_ld = 0, c_clr = 0, d_out = 0, busy = 0, priority pointer = 0 (req[0] highest).
- All outputs are registered. No combinational path from req to any output.
- FSM states: IDLE, ISSUE, ACK.
- IDLE:
  - If req != 0, pick winner w: first set bit searching from pointer upward, wrapping modulo N_REQ.
  - At the edge, go to ISSUE. Latch gnt = onehot(w), d_out = req_data slice w (or 0 if req_clr[w]), c_clr = req_clr[w], c_ld = ~req_clr[w].
  - If req == 0, stay in IDLE with all outputs at 0.
- ISSUE (exactly 1 cycle):
  - c_ld xor c_clr is high; the shared register captures at the edge ending this cycle.
  - Go to ACK. Drive c_ld = c_clr = 0 and ack = gnt. d_out holds its value.
- ACK (exactly 1 cycle):
  - gnt and ack are high for w; the register q now shows the new value.
  - Pointer <= (w+1) mod N_REQ. Go to IDLE; gnt, ack and d_out return to 0.
- Requester protocol:
  - Requester drops req[w] at the edge ending the ACK cycle, so req[w] is low in the following IDLE cycle.
  - If req[w] is still high in that IDLE cycle, it counts as a new request.
  - req_data and req_clr are sampled only in IDLE, at the grant edge. Changes while granted are ignored.
  - A requester that drops req during ISSUE/ACK still receives ack; the write is not cancelled.
- Latency and throughput:
  - Latency from req seen in IDLE to register updated: 2 edges.
  - Throughput: one write per 3 cycles.
  - Fairness: with all requesters continuously active, each is served once every 3*N_REQ cycles.
- c_ld and c_clr are never high simultaneously, and never high outside ISSUE.
- Reset in any state: next cycle is IDLE with all outputs at reset values and pointer = 0.
  - A write in ISSUE is aborted: c_ld/c_clr go low at the reset edge and no ack is issued.
  - The shared register is normally reset by the same reset.
- Simultaneous requests: only the winner is served; the others stay pending with req held.
- Pointer wrap: after serving N_REQ-1, pointer = 0.

Decomposition:
- Shared package:
  - State encoding localparams: IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2; 2'd3 is illegal and returns to IDLE.
  - Op code constants: OP_LD = 1'b0, OP_CLR = 1'b1.
- One sub-module: rr_priority_picker.
  - Combinational.
  - Inputs: req and pointer.
  - Outputs: one-hot winner and its index.
  - Reused by future bus arbiters.

Test Plan:
- Single load: req[2] = 1, req_clr[2] = 0, data 16'hA5A5 in IDLE → c_ld = 1, d_out = 16'hA5A5 next cycle; ack[2] the cycle after; attached register q = 16'hA5A5 in the ACK cycle; busy high for 2 cycles.
- All four requesters active from reset, data 16'h0001..16'h0004 → grants in order 0, 1, 2, 3; q sequence 1, 2, 3, 4; a new grant every 3 cycles.
- Clear op: q = 16'hFFFF, req[1] = 1 with req_clr[1] = 1 → c_clr = 1 and c_ld = 0 in ISSUE; q = 0 in ACK; ack[1] pulses.
- Fairness under hog: req[0] held high continuously, req[3] raised once → req[3] is served no later than the second grant after it rises; pointer wraps to 0 after serving 3.
- Reset mid-operation: assert reset during ISSUE → next cycle c_ld = c_clr = 0, gnt = 0, ack never pulses, busy = 0; the next request from req[0] wins (pointer = 0).
- Idle and late drop: req = 0 for 20 cycles → all outputs 0; req[1] dropped during ISSUE → ack[1] still pulses and the FSM returns to IDLE.
